// File: rtl/lab2_problem4_if.sv
// Operand/result bundle for the registered full-adder cell (lab2_problem4).
// No valid/ready: the cell samples A/B/C on every rising clock and X/Y are always meaningful.
interface lab2_problem4_if;
  logic A;
  logic B;
  logic C;
  logic X;
  logic Y;

  modport master (
    output A,
    output B,
    output C,
    input  X,
    input  Y
  );

  modport slave (
    input  A,
    input  B,
    input  C,
    output X,
    output Y
  );
endinterface

// File: rtl/lab2_problem4.sv
// Registered 1-bit full adder: {Y,X} = A+B+cin through a PIPE_STAGES-deep output pipeline.
// Define LAB2P4_SERIAL_EN to take cin from an internal carry register (bit-serial adder).
module lab2_problem4 #(
  parameter int PIPE_STAGES = 1
) (
  input  logic            CLK,
  input  logic            RST,
  lab2_problem4_if.slave  bus
);

  generate
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_depth
      $error("lab2_problem4: PIPE_STAGES must be in 1..4");
    end
  endgenerate

  logic       cin;
  logic       s;
  logic       co;
  logic [1:0] stage [PIPE_STAGES];

`ifdef LAB2P4_SERIAL_EN
  // C stays on the pin list for drop-in compatibility; the carry comes from cr instead.
  logic cr;
  logic unused_c;

  assign unused_c = bus.C;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cr <= 1'b0;
    end else begin
      cr <= co;
    end
  end

  assign cin = cr;
`else
  assign cin = bus.C;
`endif

  always_comb begin
    s  = bus.A ^ bus.B ^ cin;
    co = (bus.A & bus.B) | (bus.A & cin) | (bus.B & cin);
  end

  // Reset clears every stage so in-flight results never leak out after RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stage[k] <= 2'b00;
      end
    end else begin
      stage[0] <= {co, s};
      for (int k = 1; k < PIPE_STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign bus.Y = stage[PIPE_STAGES-1][1];
  assign bus.X = stage[PIPE_STAGES-1][0];

endmodule

// File: tb/tb_lab2_problem4.sv
// Bench for lab2_problem4: four instances (depths 1..4) driven in parallel,
// checked against a word-level arithmetic model plus fixed vector tables.
module tb_lab2_problem4;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  lab2_problem4_if if1 ();
  lab2_problem4_if if2 ();
  lab2_problem4_if if3 ();
  lab2_problem4_if if4 ();

  lab2_problem4 #(.PIPE_STAGES(1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1));
  lab2_problem4 #(.PIPE_STAGES(2)) dut2 (.CLK(CLK), .RST(RST), .bus(if2));
  lab2_problem4 #(.PIPE_STAGES(3)) dut3 (.CLK(CLK), .RST(RST), .bus(if3));
  lab2_problem4 #(.PIPE_STAGES(4)) dut4 (.CLK(CLK), .RST(RST), .bus(if4));

  typedef struct {
    logic       a;
    logic       b;
    logic       c;
    logic [1:0] exp;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Results ({Y,X}) sampled since the last reset, newest first.
  logic [1:0]  exp_q[$];
  int          n_bits = 0;
  logic [32:0] a_word = '0;
  logic [32:0] b_word = '0;

  function automatic logic [1:0] get_yx(int p);
    case (p)
      1:       return {if1.Y, if1.X};
      2:       return {if2.Y, if2.X};
      3:       return {if3.Y, if3.X};
      default: return {if4.Y, if4.X};
    endcase
  endfunction

  function automatic logic [1:0] model_exp(int p);
    if (exp_q.size() >= p) return exp_q[p-1];
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got {Y,X}=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model_all(input string tag);
    for (int p = 1; p <= 4; p++) begin
      check($sformatf("%s_p%0d", tag, p), get_yx(p), model_exp(p));
    end
  endtask

  task automatic set_in(input logic a, input logic b, input logic c);
    if1.A = a; if1.B = b; if1.C = c;
    if2.A = a; if2.B = b; if2.C = c;
    if3.A = a; if3.B = b; if3.C = c;
    if4.A = a; if4.B = b; if4.C = c;
  endtask

  // Reference: default mode is plain A+B+C; serial mode adds the operand words
  // streamed so far and reads off bit n (sum) and bit n+1 (carry out).
  task automatic model_edge(input logic a, input logic b, input logic c, input logic rst);
    logic [1:0]  r;
    logic [32:0] total;
    int          sum3;
    if (rst) begin
      exp_q.delete();
      n_bits = 0;
      a_word = '0;
      b_word = '0;
    end else begin
`ifdef LAB2P4_SERIAL_EN
      a_word = a_word | (33'(a) << n_bits);
      b_word = b_word | (33'(b) << n_bits);
      total  = a_word + b_word;
      r      = {total[n_bits+1], total[n_bits]};
      n_bits++;
      sum3   = 0;
`else
      total  = '0;
      sum3   = int'(a) + int'(b) + int'(c);
      r      = sum3[1:0];
`endif
      exp_q.push_front(r);
      if (exp_q.size() > 4) void'(exp_q.pop_back());
    end
  endtask

  task automatic step(input logic a, input logic b, input logic c, input logic rst);
    @(negedge CLK);
    set_in(a, b, c);
    RST = rst;
    #1;
    if (rst) begin
      for (int p = 1; p <= 4; p++) check($sformatf("async_rst_p%0d", p), get_yx(p), 2'b00);
    end
    @(posedge CLK);
    model_edge(a, b, c, rst);
    #1;
    check_model_all("model");
  endtask

  vec_t       tbl [8];
  logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  vec_t       ser [3];
  logic       r_rst;

  initial begin
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      tbl[i].a   = abc[2];
      tbl[i].b   = abc[1];
      tbl[i].c   = abc[0];
      tbl[i].exp = tt_exp[i];
    end
    ser[0] = '{a: 1'b1, b: 1'b1, c: 1'b0, exp: 2'b10};
    ser[1] = '{a: 1'b1, b: 1'b0, c: 1'b0, exp: 2'b10};
    ser[2] = '{a: 1'b0, b: 1'b0, c: 1'b0, exp: 2'b01};

    // Reset asserted between edges with all inputs high.
    RST = 1'b0;
    set_in(1'b1, 1'b1, 1'b1);
    #1 RST = 1'b1;
    #1;
    for (int p = 1; p <= 4; p++) check($sformatf("reset_async_p%0d", p), get_yx(p), 2'b00);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);

`ifndef LAB2P4_SERIAL_EN
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].c, 1'b0);
      check($sformatf("truth_abc%0d", i), get_yx(1), tbl[i].exp);
    end

    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("latency3_hit", get_yx(3), 2'b10);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("latency3_after", get_yx(3), 2'b00);

    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_mid_p2_held", get_yx(2), 2'b00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("rst_mid_p2_after%0d", i), get_yx(2), 2'b00);
    end
`else
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        step(ser[i].a, ser[i].b, (pass == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
        check($sformatf("serial_3p1_pass%0d_bit%0d", pass, i), get_yx(1), ser[i].exp);
      end
    end
`endif

    for (int i = 0; i < 300; i++) begin
      r_rst = ($urandom_range(0, 15) == 0);
`ifdef LAB2P4_SERIAL_EN
      if (n_bits >= 10) r_rst = 1'b1;
`endif
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), r_rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
